// File: rtl/core_package.sv
// rtl/core_package.sv - shared CSR addresses, trap sequencer states and mstatus helpers
package core_package;

    typedef enum logic [11:0] {
        CSR_NONE    = 12'h000,
        CSR_MSTATUS = 12'h300,
        CSR_MTVEC   = 12'h305,
        CSR_MEPC    = 12'h341,
        CSR_MCAUSE  = 12'h342,
        CSR_MTVAL   = 12'h343
    } csr_e;

    typedef enum logic [2:0] {
        IDLE,
        T_MEPC,
        T_MCAUSE,
        T_MTVAL,
        T_MSTATUS,
        T_JUMP,
        M_MSTATUS,
        M_JUMP
    } trap_seq_state_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    // Trap entry: stash MIE into MPIE, disable interrupts, previous privilege = M.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE, re-arm MPIE, previous privilege stays M.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/csr_trap_vec.sv
// rtl/csr_trap_vec.sv - trap vector target from mtvec and the captured cause
module csr_trap_vec (
    input  logic [31:0] mtvec_i,
    input  logic        interrupt_i,
    input  logic [29:0] code_i,
    output logic [31:0] vec_pc_o
);

    logic [31:0] w_base;
    logic        w_vectored;

    assign w_base     = {mtvec_i[31:2], 2'b00};
    assign w_vectored = (mtvec_i[1:0] == 2'b01) && interrupt_i;

    // Vectored mode offsets interrupts by 4*code; code bit 30 shifts out of the 32-bit result.
    always_comb begin
        vec_pc_o = w_base;
        if (w_vectored) begin
            vec_pc_o = w_base + {code_i, 2'b00};
        end
    end

endmodule

// File: rtl/csr_trap_seq.sv
// rtl/csr_trap_seq.sv - sequences trap entry / mret CSR updates over the single CSR write port
module csr_trap_seq
    import core_package::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req_i,
    input  csr_e        instr_addr_i,
    input  logic [31:0] instr_data_i,
    output logic        instr_gnt_o,
    input  logic        trap_req_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_req_i,
    output logic        trap_gnt_o,
    output logic        mret_gnt_o,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        csr_we_o,
    output csr_e        csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    trap_seq_state_e r_state;
    trap_seq_state_e w_next;
    logic [31:0]     r_cause;
    logic [31:0]     r_pc;
    logic [31:0]     r_tval;
    logic            w_take_trap;
    logic [31:0]     w_vec_pc;
    logic            w_unused_ok;

    // The low pc bits are dropped when mepc is written (aligned), so they are never read.
    assign w_unused_ok = ^r_pc[1:0] ^ r_cause[30];

    csr_trap_vec u_vec (
        .mtvec_i     (mtvec_i),
        .interrupt_i (r_cause[31]),
        .code_i      (r_cause[29:0]),
        .vec_pc_o    (w_vec_pc)
    );

    // State register; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture trap info at acceptance so later requester changes cannot leak in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cause <= 32'h0;
            r_pc    <= 32'h0;
            r_tval  <= 32'h0;
        end else if (w_take_trap) begin
            r_cause <= trap_cause_i;
            r_pc    <= trap_pc_i;
            r_tval  <= trap_tval_i;
        end
    end

    // Arbitration, next state and the write/redirect outputs; everything forced low in reset.
    always_comb begin
        w_next        = r_state;
        w_take_trap   = 1'b0;
        instr_gnt_o   = 1'b0;
        trap_gnt_o    = 1'b0;
        mret_gnt_o    = 1'b0;
        csr_we_o      = 1'b0;
        csr_waddr_o   = CSR_NONE;
        csr_wdata_o   = 32'h0;
        redirect_o    = 1'b0;
        redirect_pc_o = 32'h0;
        busy_o        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (trap_req_i) begin
                    trap_gnt_o  = 1'b1;
                    w_take_trap = 1'b1;
                    w_next      = T_MEPC;
                end else if (mret_req_i) begin
                    mret_gnt_o = 1'b1;
                    w_next     = M_MSTATUS;
                end else if (instr_req_i) begin
                    instr_gnt_o = 1'b1;
                    csr_we_o    = 1'b1;
                    csr_waddr_o = instr_addr_i;
                    csr_wdata_o = instr_data_i;
                end
            end
            T_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = {r_pc[31:2], 2'b00};
                w_next      = T_MCAUSE;
            end
            T_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = r_cause;
                w_next      = T_MTVAL;
            end
            T_MTVAL: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MTVAL;
                csr_wdata_o = r_tval;
                w_next      = T_MSTATUS;
            end
            T_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mstatus_on_trap(mstatus_i);
                w_next      = T_JUMP;
            end
            T_JUMP: begin
                redirect_o    = 1'b1;
                redirect_pc_o = w_vec_pc;
                w_next        = IDLE;
            end
            M_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mstatus_on_mret(mstatus_i);
                w_next      = M_JUMP;
            end
            M_JUMP: begin
                redirect_o    = 1'b1;
                redirect_pc_o = mepc_i;
                w_next        = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (!reset) begin
            w_next        = IDLE;
            w_take_trap   = 1'b0;
            instr_gnt_o   = 1'b0;
            trap_gnt_o    = 1'b0;
            mret_gnt_o    = 1'b0;
            csr_we_o      = 1'b0;
            csr_waddr_o   = CSR_NONE;
            csr_wdata_o   = 32'h0;
            redirect_o    = 1'b0;
            redirect_pc_o = 32'h0;
            busy_o        = 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_trap_seq.sv
// tb/tb_csr_trap_seq.sv - self-checking bench for csr_trap_seq with a queued action model
module tb_csr_trap_seq;
    import core_package::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req_i;
    csr_e        instr_addr_i;
    logic [31:0] instr_data_i;
    logic        instr_gnt_o;
    logic        trap_req_i;
    logic [31:0] trap_cause_i, trap_pc_i, trap_tval_i;
    logic        mret_req_i;
    logic        trap_gnt_o, mret_gnt_o;
    logic [31:0] mstatus_i, mtvec_i, mepc_i;
    logic        csr_we_o;
    csr_e        csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    always #5 clk = ~clk;

    csr_trap_seq dut (
        .clk(clk), .reset(reset),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_data_i(instr_data_i),
        .instr_gnt_o(instr_gnt_o),
        .trap_req_i(trap_req_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
        .trap_tval_i(trap_tval_i),
        .mret_req_i(mret_req_i), .trap_gnt_o(trap_gnt_o), .mret_gnt_o(mret_gnt_o),
        .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Pending actions: one entry per future busy cycle.
    // 0 = fixed write (addr/data), 1 = trap mstatus, 2 = trap jump (data = cause),
    // 3 = mret mstatus, 4 = mret jump.
    int          q_kind[$];
    logic [11:0] q_addr[$];
    logic [31:0] q_data[$];
    logic        g_trap, g_mret, g_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_trap_ms(input logic [31:0] m);
        return (m & ~32'h0000_1888) | (((m >> 3) & 32'h1) << 7) | 32'h0000_1800;
    endfunction

    function automatic logic [31:0] m_mret_ms(input logic [31:0] m);
        return (m & ~32'h0000_1888) | (((m >> 7) & 32'h1) << 3) | 32'h0000_1880;
    endfunction

    function automatic logic [31:0] m_vec(input logic [31:0] tv, input logic [31:0] cause);
        logic [31:0] base;
        base = tv & ~32'h3;
        if ((tv & 32'h3) == 32'h1 && cause >= 32'h8000_0000) return base + cause * 4;
        return base;
    endfunction

    task automatic push(input int k, input logic [11:0] a, input logic [31:0] d);
        q_kind.push_back(k);
        q_addr.push_back(a);
        q_data.push_back(d);
    endtask

    // Called at posedge+1: wait to mid-cycle, compare every output with the model.
    task automatic settle();
        logic        e_ig, e_tg, e_mg, e_we, e_rd, e_busy;
        logic [31:0] e_addr, e_data, e_pc;
        #4;
        {e_ig, e_tg, e_mg, e_we, e_rd, e_busy} = '0;
        e_addr = 0; e_data = 0; e_pc = 0;
        if (reset) begin
            if (q_kind.size() == 0) begin
                if (trap_req_i) e_tg = 1;
                else if (mret_req_i) e_mg = 1;
                else if (instr_req_i) begin
                    e_ig = 1; e_we = 1;
                    e_addr = 32'(instr_addr_i); e_data = instr_data_i;
                end
            end else begin
                e_busy = 1;
                case (q_kind[0])
                    0: begin e_we = 1; e_addr = 32'(q_addr[0]); e_data = q_data[0]; end
                    1: begin e_we = 1; e_addr = 32'h300; e_data = m_trap_ms(mstatus_i); end
                    2: begin e_rd = 1; e_pc = m_vec(mtvec_i, q_data[0]); end
                    3: begin e_we = 1; e_addr = 32'h300; e_data = m_mret_ms(mstatus_i); end
                    default: begin e_rd = 1; e_pc = mepc_i; end
                endcase
            end
        end
        chk("instr_gnt", 32'(instr_gnt_o), 32'(e_ig));
        chk("trap_gnt", 32'(trap_gnt_o), 32'(e_tg));
        chk("mret_gnt", 32'(mret_gnt_o), 32'(e_mg));
        chk("csr_we", 32'(csr_we_o), 32'(e_we));
        chk("csr_waddr", 32'(csr_waddr_o), e_addr);
        chk("csr_wdata", csr_wdata_o, e_data);
        chk("redirect", 32'(redirect_o), 32'(e_rd));
        chk("redirect_pc", redirect_pc_o, e_pc);
        chk("busy", 32'(busy_o), 32'(e_busy));
    endtask

    // Clock edge: advance the model with the inputs that were stable across the edge.
    task automatic advance();
        @(posedge clk);
        g_trap = 0; g_mret = 0; g_instr = 0;
        if (!reset) begin
            q_kind.delete(); q_addr.delete(); q_data.delete();
        end else if (q_kind.size() == 0) begin
            if (trap_req_i) begin
                g_trap = 1;
                push(0, 12'h341, trap_pc_i & ~32'h3);
                push(0, 12'h342, trap_cause_i);
                push(0, 12'h343, trap_tval_i);
                push(1, 12'h0, 32'h0);
                push(2, 12'h0, trap_cause_i);
            end else if (mret_req_i) begin
                g_mret = 1;
                push(3, 12'h0, 32'h0);
                push(4, 12'h0, 32'h0);
            end else if (instr_req_i) begin
                g_instr = 1;
            end
        end else begin
            void'(q_kind.pop_front()); void'(q_addr.pop_front()); void'(q_data.pop_front());
        end
        #1;
    endtask

    csr_e addr_tab [5] = '{CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL};

    initial begin
        reset = 0;
        instr_req_i = 0; instr_addr_i = CSR_MSTATUS; instr_data_i = 0;
        trap_req_i = 0; trap_cause_i = 0; trap_pc_i = 0; trap_tval_i = 0;
        mret_req_i = 0; mstatus_i = 0; mtvec_i = 0; mepc_i = 0;
        @(posedge clk); #1;

        // reset: everything low even with requests pending
        trap_req_i = 1; instr_req_i = 1;
        settle();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_tgnt", 32'(trap_gnt_o), 0);
        chk("rst_we", 32'(csr_we_o), 0);
        advance();
        trap_req_i = 0; instr_req_i = 0; reset = 1;
        settle(); chk("idle_busy", 32'(busy_o), 0); advance();

        // trap, direct mode
        trap_req_i = 1; trap_cause_i = 32'h2; trap_pc_i = 32'h106; trap_tval_i = 32'hDEAD;
        mtvec_i = 32'h1000; mstatus_i = 32'h0;
        settle(); chk("t1_gnt", 32'(trap_gnt_o), 1); advance(); trap_req_i = 0;
        trap_cause_i = 32'hFFFF_FFFF; trap_pc_i = 32'h0; trap_tval_i = 32'h0;
        settle(); chk("t1_mepc_a", 32'(csr_waddr_o), 32'h341); chk("t1_mepc_d", csr_wdata_o, 32'h104); advance();
        settle(); chk("t1_mcause_a", 32'(csr_waddr_o), 32'h342); chk("t1_mcause_d", csr_wdata_o, 32'h2); advance();
        settle(); chk("t1_mtval_a", 32'(csr_waddr_o), 32'h343); chk("t1_mtval_d", csr_wdata_o, 32'hDEAD); advance();
        settle(); chk("t1_mst_a", 32'(csr_waddr_o), 32'h300); chk("t1_mst_d", csr_wdata_o, 32'h1800); advance();
        settle(); chk("t1_redir", 32'(redirect_o), 1); chk("t1_pc", redirect_pc_o, 32'h1000);
        chk("t1_jump_we", 32'(csr_we_o), 0); advance();
        settle(); chk("t1_done", 32'(busy_o), 0); advance();

        // trap, vectored interrupt
        trap_req_i = 1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h400; trap_tval_i = 0;
        mtvec_i = 32'h1001; mstatus_i = 32'h8;
        settle(); advance(); trap_req_i = 0;
        for (int i = 0; i < 3; i++) begin settle(); advance(); end
        settle(); chk("t2_mst_d", csr_wdata_o, 32'h1880); advance();
        settle(); chk("t2_pc", redirect_pc_o, 32'h101C); advance();

        // mret
        mret_req_i = 1; mstatus_i = 32'h80; mepc_i = 32'h2000;
        settle(); chk("m_gnt", 32'(mret_gnt_o), 1); advance(); mret_req_i = 0;
        settle(); chk("m_mst_a", 32'(csr_waddr_o), 32'h300); chk("m_mst_d", csr_wdata_o, 32'h1888); advance();
        settle(); chk("m_redir", 32'(redirect_o), 1); chk("m_pc", redirect_pc_o, 32'h2000); advance();

        // all three requesters at once
        trap_req_i = 1; mret_req_i = 1; instr_req_i = 1;
        instr_addr_i = CSR_MTVEC; instr_data_i = 32'h1234_5678;
        settle(); chk("p_tgnt", 32'(trap_gnt_o), 1); chk("p_mgnt", 32'(mret_gnt_o), 0);
        chk("p_ignt", 32'(instr_gnt_o), 0); advance();
        trap_req_i = 0; mret_req_i = 0;
        for (int i = 0; i < 5; i++) begin settle(); chk("p_ig_busy", 32'(instr_gnt_o), 0); advance(); end
        settle(); chk("p_igrant", 32'(instr_gnt_o), 1); chk("p_iaddr", 32'(csr_waddr_o), 32'h305);
        chk("p_idata", csr_wdata_o, 32'h1234_5678); advance();
        instr_req_i = 0;

        // reset in T_MCAUSE
        trap_req_i = 1; trap_cause_i = 32'h5;
        settle(); advance(); trap_req_i = 0;
        settle(); advance();
        reset = 0;
        settle(); chk("r_we", 32'(csr_we_o), 0); chk("r_busy", 32'(busy_o), 0); advance();
        reset = 1;
        for (int i = 0; i < 6; i++) begin settle(); chk("r_noredir", 32'(redirect_o), 0); advance(); end

        // randomized traffic with held requests
        for (int c = 0; c < 3000; c++) begin
            if (g_trap) trap_req_i = 0;
            if (g_mret) mret_req_i = 0;
            if (g_instr) instr_req_i = 0;
            if (!trap_req_i && $urandom_range(0, 11) == 0) begin
                trap_req_i = 1; trap_cause_i = $urandom; trap_pc_i = $urandom; trap_tval_i = $urandom;
            end
            if (!mret_req_i && $urandom_range(0, 9) == 0) mret_req_i = 1;
            if (!instr_req_i && $urandom_range(0, 2) == 0) begin
                instr_req_i = 1; instr_addr_i = addr_tab[$urandom_range(0, 4)]; instr_data_i = $urandom;
            end
            mstatus_i = $urandom; mepc_i = $urandom;
            mtvec_i = $urandom;
            if ($urandom_range(0, 1) == 0) mtvec_i[1:0] = 2'b01;
            reset = ($urandom_range(0, 199) != 0);
            settle();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_trap_seq.md
CSR_TRAP_SEQ -- requirements
Module: csr_trap_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports instr_req_i (in, 1), instr_addr_i (in, csr_e), instr_data_i (in, 32) carrying a pipeline CSR write request from the csr datapath.
REQ-004 SHALL have port instr_gnt_o, out, 1, granting the instruction write this cycle.
REQ-005 SHALL have ports trap_req_i (in, 1), trap_cause_i (in, 32), trap_pc_i (in, 32), trap_tval_i (in, 32) for exception/interrupt entry.
REQ-006 SHALL have ports mret_req_i (in, 1), trap_gnt_o (out, 1) and mret_gnt_o (out, 1).
REQ-007 SHALL have inputs mstatus_i, mtvec_i, mepc_i (32 each) carrying current CSR file contents.
REQ-008 SHALL have outputs csr_we_o (1), csr_waddr_o (csr_e), csr_wdata_o (32) forming the single CSR file write port.
REQ-009 SHALL have outputs redirect_o (1), redirect_pc_o (32), busy_o (1).

Function
REQ-010 SHALL implement states IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, T_JUMP, M_MSTATUS, M_JUMP.
REQ-011 SHALL arbitrate in IDLE with fixed priority trap_req_i > mret_req_i > instr_req_i.
REQ-012 SHALL assert trap_gnt_o or mret_gnt_o for exactly one cycle, in the IDLE cycle the request is accepted.
REQ-013 SHALL register trap_cause_i, trap_pc_i, trap_tval_i on trap acceptance and use only registered copies afterwards.
REQ-014 SHALL go IDLE->T_MEPC on trap grant, then T_MCAUSE, T_MTVAL, T_MSTATUS, T_JUMP, IDLE, one state per cycle.
REQ-015 SHALL write in T_MEPC: {pc[31:2],2'b00}; T_MCAUSE: cause; T_MTVAL: tval; T_MSTATUS: mstatus_i with MPIE(bit7)=MIE(bit3), MIE=0, MPP[12:11]=2'b11.
REQ-016 SHALL go IDLE->M_MSTATUS->M_JUMP->IDLE on mret grant; M_MSTATUS writes mstatus_i with MIE=MPIE, MPIE=1, MPP=2'b11.
REQ-017 SHALL pulse redirect_o for one cycle in T_JUMP and M_JUMP, with csr_we_o low in those states.
REQ-018 SHALL drive redirect_pc_o in T_JUMP as {mtvec_i[31:2],2'b00} + (cause[30:0]<<2) when mtvec_i[1:0]==2'b01 and cause[31]==1, else {mtvec_i[31:2],2'b00}; addition modulo 2^32.
REQ-019 SHALL drive redirect_pc_o = mepc_i in M_JUMP.
REQ-020 SHALL grant instr_req_i combinationally only in IDLE with trap_req_i and mret_req_i low, passing addr/data through with csr_we_o=1 the same cycle.
REQ-021 SHALL assert busy_o in every non-IDLE state; requesters hold req high until granted.
REQ-022 SHALL ignore trap_req_i and mret_req_i while busy; no request is queued.
REQ-023 SHALL issue at most one CSR write per cycle; csr_we_o=0 in IDLE without instr grant.
REQ-024 SHALL drive csr_waddr_o/csr_wdata_o to 0 whenever csr_we_o=0.
REQ-025 SHALL treat simultaneous trap_req_i and instr_req_i in IDLE as trap-only; instr_gnt_o=0.

Reset
REQ-026 SHALL on reset low force state IDLE and all registered captures to 0 immediately.
REQ-027 SHALL hold all outputs 0 while reset is low.
REQ-028 SHALL, when reset is applied mid-sequence, abandon the sequence; completed writes stand; no redirect issued.

Structure
REQ-029 SHALL place csr_e addresses MSTATUS=0x300, MTVEC=0x305, MEPC=0x341, MCAUSE=0x342, MTVAL=0x343 and typedef trap_seq_state_e in core_package.
REQ-030 SHALL place mstatus bit-index constants MIE=3, MPIE=7, MPP=12:11 in core_package.
REQ-031 SHALL compute the vector address in one combinational sub-module csr_trap_vec.

Verification
REQ-032 Trap, cause=0x2, pc=0x106, tval=0xDEAD, mtvec=0x1000 -> writes MEPC=0x104, MCAUSE=0x2, MTVAL=0xDEAD, then MSTATUS, then redirect_pc_o=0x1000 on cycle 5.
REQ-033 Trap, cause=0x80000007, mtvec=0x1001 -> redirect_pc_o=0x101C; mstatus_i=0x8 written as 0x1880.
REQ-034 MRET, mstatus_i=0x80, mepc_i=0x2000 -> MSTATUS written 0x1888, next cycle redirect_pc_o=0x2000.
REQ-035 trap_req_i, mret_req_i, instr_req_i all high in IDLE -> trap_gnt_o=1, others 0; instr granted first IDLE cycle after T_JUMP.
REQ-036 reset low during T_MCAUSE -> outputs 0 immediately; after release IDLE, busy_o=0, no redirect_o.
